// File: rtl/sudoku_board_streamer_if.sv
// sudoku_board_streamer_if: recogniser-side write port and solver-side cell stream of the board streamer.
interface sudoku_board_streamer_if;
  logic clear;
  logic wr_en;
  logic [3:0] wr_row;
  logic [3:0] wr_col;
  logic [3:0] wr_digit;
  logic start;
  logic busy;
  logic reading;
  logic [10:0] data;
  logic sent;
  logic wr_err;
  modport master (
    output clear, wr_en, wr_row, wr_col, wr_digit, start,
    input busy, reading, data, sent, wr_err
  );
  modport slave (
    input clear, wr_en, wr_row, wr_col, wr_digit, start,
    output busy, reading, data, sent, wr_err
  );
endinterface

// File: rtl/sudoku_board_streamer.sv
// sudoku_board_streamer: buffers an 81-cell board from random-access writes and streams it column-major to the solver.
module sudoku_board_streamer (
  input logic clk,
  input logic rst_n,
  sudoku_board_streamer_if.slave bus
);
  localparam int N = 9;
  localparam int CELLS = N * N;
  localparam int DATA_W = 11;
  localparam logic [DATA_W-1:0] EMPTY = 11'h400;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [6:0] k, k_d;
  logic [DATA_W-1:0] cells [CELLS];
  logic [DATA_W-1:0] data_d, enc, cell0;
  logic busy_d, reading_d, sent_d, wr_err_d;
  logic fmt_ok, wr_ok;
  logic [6:0] wr_idx;
  // Cells are stored column-major so the stream index addresses the buffer directly.
  assign fmt_ok = bus.wr_row < 4'(N) && bus.wr_col < 4'(N) && bus.wr_digit <= 4'(N);
  assign wr_ok = state == IDLE && bus.wr_en && fmt_ok;
  assign wr_idx = 7'(bus.wr_col) * 7'(N) + 7'(bus.wr_row);
  assign enc = bus.wr_digit == 4'd0 ? EMPTY : DATA_W'(1) << bus.wr_digit;
  // Bypass so a write/clear coinciding with start is visible in the first streamed word.
  assign cell0 = wr_ok && wr_idx == 7'd0 ? enc : bus.clear ? EMPTY : cells[0];
  always_comb begin
    state_d = state;
    k_d = k;
    busy_d = 1'b0;
    reading_d = 1'b0;
    data_d = '0;
    sent_d = 1'b0;
    wr_err_d = bus.wr_en && (state == SEND || !fmt_ok);
    if (state == IDLE) begin
      if (bus.start) begin
        state_d = SEND;
        k_d = 7'd0;
        busy_d = 1'b1;
        reading_d = 1'b1;
        data_d = cell0;
      end
    end else if (k == 7'(CELLS - 1)) begin
      state_d = IDLE;
      k_d = 7'd0;
      sent_d = 1'b1;
    end else begin
      k_d = k + 7'd1;
      busy_d = 1'b1;
      reading_d = 1'b1;
      data_d = cells[k + 7'd1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= 7'd0;
      bus.busy <= 1'b0;
      bus.reading <= 1'b0;
      bus.data <= '0;
      bus.sent <= 1'b0;
      bus.wr_err <= 1'b0;
    end else begin
      state <= state_d;
      k <= k_d;
      bus.busy <= busy_d;
      bus.reading <= reading_d;
      bus.data <= data_d;
      bus.sent <= sent_d;
      bus.wr_err <= wr_err_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= EMPTY;
    end else begin
      for (int i = 0; i < CELLS; i++)
        cells[i] <= wr_ok && wr_idx == 7'(i) ? enc : (state == IDLE && bus.clear) ? EMPTY : cells[i];
    end
  end
endmodule

// File: tb/tb_sudoku_board_streamer.sv
// tb_sudoku_board_streamer: directed and randomized checks of the board streamer against a digit-grid model.
module tb_sudoku_board_streamer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int board [9][9];
  sudoku_board_streamer_if bus ();
  sudoku_board_streamer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [10:0] word_of(input int d);
    logic [10:0] one;
    one = 11'd1;
    return d == 0 ? 11'h400 : one << d;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic empty_model;
    foreach (board[i, j]) board[i][j] = 0;
  endtask
  task automatic wr(input int r, input int c, input int d, input bit clr);
    bit ok;
    ok = r <= 8 && c <= 8 && d <= 9;
    bus.wr_en = 1'b1;
    bus.wr_row = 4'(r);
    bus.wr_col = 4'(c);
    bus.wr_digit = 4'(d);
    bus.clear = clr;
    tick;
    chk($sformatf("wr_err r%0d c%0d d%0d", r, c, d), 11'(bus.wr_err), 11'(!ok));
    chk("busy idle", 11'(bus.busy), 11'd0);
    if (clr) empty_model();
    if (ok) board[r][c] = d;
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
  endtask
  // hold keeps start high through the stream; err_at injects wr_en/clear/start during SEND at that index.
  task automatic stream(input bit hold, input int err_at);
    bus.start = 1'b1;
    tick;
    bus.start = hold;
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
    for (int k = 0; k < 81; k++) begin
      chk($sformatf("reading k=%0d", k), 11'(bus.reading), 11'd1);
      chk($sformatf("busy k=%0d", k), 11'(bus.busy), 11'd1);
      chk($sformatf("data k=%0d", k), bus.data, word_of(board[k % 9][k / 9]));
      chk($sformatf("wr_err k=%0d", k), 11'(bus.wr_err), 11'(k > 0 && k - 1 == err_at));
      chk($sformatf("sent k=%0d", k), 11'(bus.sent), 11'd0);
      if (k == err_at) begin
        bus.wr_en = 1'b1;
        bus.clear = 1'b1;
        bus.start = 1'b1;
        bus.wr_row = 4'd0;
        bus.wr_col = 4'd0;
        bus.wr_digit = 4'($urandom_range(1, 9));
      end
      tick;
      if (k == err_at) begin
        bus.wr_en = 1'b0;
        bus.clear = 1'b0;
        bus.start = hold;
      end
    end
    chk("sent pulse", 11'(bus.sent), 11'd1);
    chk("reading after", 11'(bus.reading), 11'd0);
    chk("busy after", 11'(bus.busy), 11'd0);
    chk("data after", bus.data, 11'd0);
    if (!hold) begin
      tick;
      chk("sent one cycle", 11'(bus.sent), 11'd0);
      chk("reading idle", 11'(bus.reading), 11'd0);
    end
  endtask
  initial begin
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_row = 4'd0;
    bus.wr_col = 4'd0;
    bus.wr_digit = 4'd0;
    bus.start = 1'b0;
    empty_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 11'(bus.busy), 11'd0);
    chk("rst reading", 11'(bus.reading), 11'd0);
    chk("rst data", bus.data, 11'd0);
    chk("rst sent", 11'(bus.sent), 11'd0);
    chk("rst wr_err", 11'(bus.wr_err), 11'd0);
    rst_n = 1'b1;
    tick;
    stream(1'b0, -1);
    wr(0, 0, 5, 1'b0);
    wr(1, 0, 3, 1'b0);
    wr(0, 1, 9, 1'b0);
    wr(8, 8, 1, 1'b0);
    stream(1'b0, -1);
    chk("direct k0", word_of(board[0][0]), 11'h020);
    bus.wr_en = 1'b1;
    bus.wr_row = 4'd0;
    bus.wr_col = 4'd0;
    bus.wr_digit = 4'd7;
    board[0][0] = 7;
    stream(1'b0, -1);
    wr(4, 4, 2, 1'b1);
    stream(1'b0, -1);
    wr(9, 0, 3, 1'b0);
    wr(2, 2, 12, 1'b0);
    wr(0, 9, 1, 1'b0);
    stream(1'b0, 20);
    for (int round = 0; round < 3; round++) begin
      repeat (25) wr($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 11),
                     $urandom_range(0, 19) == 0);
      stream(1'b0, $urandom_range(0, 79));
    end
    stream(1'b1, -1);
    stream(1'b0, -1);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (40) tick;
    chk("pre-reset data k=40", bus.data, word_of(board[4][4]));
    rst_n = 1'b0;
    #1;
    chk("async reading", 11'(bus.reading), 11'd0);
    chk("async busy", 11'(bus.busy), 11'd0);
    chk("async data", bus.data, 11'd0);
    empty_model();
    tick;
    tick;
    rst_n = 1'b1;
    repeat (3) begin
      tick;
      chk("no sent after reset", 11'(bus.sent), 11'd0);
      chk("no reading after reset", 11'(bus.reading), 11'd0);
    end
    stream(1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
